// File: rtl/poco_mem_pkg.sv
// poco_mem_pkg: shared FSM state type and default sizes for the poco memory access controller
//   state_t                   IDLE, SETUP, READ, WRITE, DONE
//   AW_DEF / DW_DEF           default RAM address / data widths
//   RD_WAIT_DEF / WR_WAIT_DEF default strobe lengths in cycles
//   CNT_W                     wait counter width for the default strobe lengths
package poco_mem_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, READ, WRITE, DONE} state_t;
    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
    localparam int RD_WAIT_DEF = 2;
    localparam int WR_WAIT_DEF = 1;
    localparam int CNT_W = $clog2(RD_WAIT_DEF > WR_WAIT_DEF ? RD_WAIT_DEF : WR_WAIT_DEF) + 1;
endpackage

// File: rtl/wait_cnt.sv
// wait_cnt: loadable down-counter that saturates at zero, used to time RAM strobes
//   clk, rst  clock and asynchronous active-low reset
//   ld, val   load val (has priority over dec)
//   dec       decrement by one, holding at zero
//   zero      count is zero
module wait_cnt
    import poco_mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic         dec,
    input  logic [W-1:0] val,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else if (ld)
            cnt <= val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;

    assign zero = (cnt == '0);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences CPU<->RAM read/write transfers with wait states
//   clk, rst               clock and asynchronous active-low reset
//   req_rd, req_wr         transfer requests, sampled in IDLE or DONE
//   addr, wdata            transfer address and write data, latched on accept
//   busy, done, err        SETUP..strobe phase / completion pulse / collision pulse
//   rdata                  last read data
//   out_ram, ram_dout      RAM address and write data pins
//   ram_oe                 io_ram tri-state enable (io_ram = ram_oe ? ram_dout : 'z)
//   ram_din                io_ram sampled value
//   r_ram, w_ram           RAM read / write strobes
module mem_access_ctrl
    import poco_mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] out_ram,
    output logic [DW-1:0] ram_dout,
    output logic          ram_oe,
    input  logic [DW-1:0] ram_din,
    output logic          r_ram,
    output logic          w_ram
);
    localparam int CW = $clog2(RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT) + 1;
    localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LD = CW'(WR_WAIT - 1);

    state_t state;
    logic   wr_q;
    logic   zero;

    wait_cnt #(.W(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (state == SETUP),
        .dec  (state == READ || state == WRITE),
        .val  (wr_q ? WR_LD : RD_LD),
        .zero (zero)
    );

    // Outputs are assigned on the transition into each state so every pin is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            r_ram    <= 1'b0;
            w_ram    <= 1'b0;
            ram_oe   <= 1'b0;
            out_ram  <= '0;
            ram_dout <= '0;
            rdata    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    ram_oe <= 1'b0;
                    if (req_rd ^ req_wr) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        wr_q    <= req_wr;
                        out_ram <= addr;
                        // Write data goes onto the bus a cycle ahead of w_ram.
                        ram_oe  <= req_wr;
                        if (req_wr)
                            ram_dout <= wdata;
                    end else begin
                        state <= IDLE;
                        err   <= req_rd & req_wr;
                    end
                end
                SETUP: begin
                    state <= wr_q ? WRITE : READ;
                    r_ram <= ~wr_q;
                    w_ram <= wr_q;
                end
                READ:
                    if (zero) begin
                        state <= DONE;
                        r_ram <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rdata <= ram_din;
                    end
                WRITE:
                    // ram_oe stays high into DONE to hold data past the w_ram edge.
                    if (zero) begin
                        state <= DONE;
                        w_ram <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
